// File: rtl/bsg_gateway_reset_seq_pkg.sv
// Shared types for the gateway reset sequencer: the 3-bit state encoding,
// the bundle of sequencer outputs, and the Moore decode from state to outputs.
package bsg_gateway_reset_seq_pkg;

    typedef enum logic [2:0] {
        S_PRE   = 3'd0,
        S_LRST  = 3'd1,
        S_LWAIT = 3'd2,
        S_LEN   = 3'd3,
        S_CRUN  = 3'd4,
        S_DONE  = 3'd5
    } bsg_gateway_reset_seq_state_e;

    typedef struct packed {
        logic link_reset;
        logic link_enable;
        logic chip_reset;
        logic node_en;
        logic done;
    } bsg_gateway_reset_seq_out_s;

    // Output values held while the board reset is asserted (same as S_PRE)
    localparam bsg_gateway_reset_seq_out_s seq_out_reset_lp = '{
        link_reset:  1'b0,
        link_enable: 1'b0,
        chip_reset:  1'b1,
        node_en:     1'b0,
        done:        1'b0
    };

    // Moore decode: the link is reset first, then enabled, then the chip is
    // released, and only then is the traffic node allowed to run.
    function automatic bsg_gateway_reset_seq_out_s decode_outputs(
        input bsg_gateway_reset_seq_state_e s
    );
        bsg_gateway_reset_seq_out_s o;
        o             = seq_out_reset_lp;
        o.link_reset  = (s == S_LRST);
        o.link_enable = (s == S_LEN) || (s == S_CRUN) || (s == S_DONE);
        o.chip_reset  = !((s == S_CRUN) || (s == S_DONE));
        o.node_en     = (s == S_DONE);
        o.done        = (s == S_DONE);
        return o;
    endfunction

endpackage

// File: rtl/bsg_gateway_reset_seq_timer.sv
// Clearable saturating up-counter. Counts one per clock, holds at all-ones
// rather than wrapping, and returns to zero whenever clear_i is high.
module bsg_gateway_reset_seq_timer #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    output logic [width_p-1:0] count_o
);

    // Count up, saturating at the maximum value; clear wins over counting
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (count_o != {width_p{1'b1}}) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_gateway_reset_sequencer.sv
// Gateway power-up reset sequencer: steps the DDR link and chip resets through
// a fixed order, spending step_cycles_p cycles in each step before enabling
// the traffic node. Optional heartbeat watchdog, enabled by defining
// BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN, re-runs the sequence when the downstream
// node goes silent in S_DONE. All outputs are registered decodes of state.
module bsg_gateway_reset_sequencer
    import bsg_gateway_reset_seq_pkg::*;
#(
    parameter int step_cycles_p     = 5000,
    parameter int watchdog_cycles_p = 65535
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       restart_i,
    input  logic       heartbeat_i,
    output logic       link_reset_o,
    output logic       link_enable_o,
    output logic       chip_reset_o,
    output logic       node_en_o,
    output logic       done_o,
    output logic [2:0] state_o,
    output logic [7:0] timeout_count_o
);

    localparam int step_w_lp = $clog2(step_cycles_p + 1);
    localparam logic [step_w_lp-1:0] step_last_lp = step_w_lp'(step_cycles_p - 1);

    bsg_gateway_reset_seq_state_e state_r, state_n;
    bsg_gateway_reset_seq_out_s   out_r, out_n;

    logic [step_w_lp-1:0] step_cnt;
    logic                 step_clear;
    logic                 step_expired;
    logic                 wd_fire;

    // The step timer restarts on every state change and is pinned at zero
    // while restart_i is held, so S_PRE lasts a full step after it drops.
    assign step_clear   = restart_i || (state_n != state_r);
    assign step_expired = (step_cnt == step_last_lp);

    bsg_gateway_reset_seq_timer #(.width_p(step_w_lp)) u_step_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (step_clear),
        .count_o   (step_cnt)
    );

`ifdef BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN
    localparam int wd_w_lp = $clog2(watchdog_cycles_p + 1);
    localparam logic [wd_w_lp-1:0] wd_last_lp = wd_w_lp'(watchdog_cycles_p - 1);

    logic [wd_w_lp-1:0] wd_cnt;
    logic [7:0]         timeout_cnt_r;

    // Silence timer: only runs in S_DONE, any heartbeat starts it over
    bsg_gateway_reset_seq_timer #(.width_p(wd_w_lp)) u_wd_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (heartbeat_i || (state_r != S_DONE)),
        .count_o   (wd_cnt)
    );

    // The edge that would bring the silence count to watchdog_cycles_p is
    // the one that forces the restart; an explicit restart takes precedence.
    assign wd_fire = (state_r == S_DONE) && !heartbeat_i && !restart_i
                     && (wd_cnt == wd_last_lp);

    // Saturating count of watchdog-initiated restarts
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timeout_cnt_r <= 8'd0;
        end else if (wd_fire && (timeout_cnt_r != 8'hFF)) begin
            timeout_cnt_r <= timeout_cnt_r + 8'd1;
        end
    end

    assign timeout_count_o = timeout_cnt_r;
`else
    // Heartbeat stays on the port list but has no effect in this build
    logic unused_heartbeat;
    assign unused_heartbeat = heartbeat_i;
    assign wd_fire          = 1'b0;
    assign timeout_count_o  = 8'd0;
`endif

    // State and output registers; outputs are loaded from the decode of the
    // next state so they change on the same edge as state_o.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= S_PRE;
            out_r   <= seq_out_reset_lp;
        end else begin
            state_r <= state_n;
            out_r   <= out_n;
        end
    end

    // Next state: restart beats watchdog, which beats the step advance
    always_comb begin
        state_n = state_r;
        if (restart_i || wd_fire) begin
            state_n = S_PRE;
        end else if (step_expired) begin
            case (state_r)
                S_PRE:   state_n = S_LRST;
                S_LRST:  state_n = S_LWAIT;
                S_LWAIT: state_n = S_LEN;
                S_LEN:   state_n = S_CRUN;
                S_CRUN:  state_n = S_DONE;
                default: state_n = state_r;
            endcase
        end
    end

    // Output decode of the state about to be registered
    always_comb begin
        out_n = decode_outputs(state_n);
    end

    assign link_reset_o  = out_r.link_reset;
    assign link_enable_o = out_r.link_enable;
    assign chip_reset_o  = out_r.chip_reset;
    assign node_en_o     = out_r.node_en;
    assign done_o        = out_r.done;
    assign state_o       = state_r;

endmodule

// File: tb/tb_bsg_gateway_reset_sequencer.sv
// Directed bench for bsg_gateway_reset_sequencer. Three instances share one
// clock: N=4 (main timeline), N=1 (one cycle per state) and N=2 with an
// 8-cycle watchdog. "Edge 0" is the posedge at which reset_n is released
// (or at which a restart is sampled); later edges are numbered from it.
module tb_bsg_gateway_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: N=4
    logic       a_rst_n = 1'b0, a_restart = 1'b0, a_hb = 1'b0;
    logic       a_lrst, a_len, a_crst, a_nen, a_done;
    logic [2:0] a_state;
    logic [7:0] a_tmo;
    // Instance B: N=1
    logic       b_rst_n = 1'b0, b_restart = 1'b0, b_hb = 1'b0;
    logic       b_lrst, b_len, b_crst, b_nen, b_done;
    logic [2:0] b_state;
    logic [7:0] b_tmo;
    // Instance C: N=2, watchdog 8
    logic       c_rst_n = 1'b0, c_restart = 1'b0, c_hb = 1'b0;
    logic       c_lrst, c_len, c_crst, c_nen, c_done;
    logic [2:0] c_state;
    logic [7:0] c_tmo;

    bsg_gateway_reset_sequencer #(.step_cycles_p(4)) u_a (
        .clk_i(clk), .reset_n_i(a_rst_n), .restart_i(a_restart), .heartbeat_i(a_hb),
        .link_reset_o(a_lrst), .link_enable_o(a_len), .chip_reset_o(a_crst),
        .node_en_o(a_nen), .done_o(a_done), .state_o(a_state), .timeout_count_o(a_tmo)
    );

    bsg_gateway_reset_sequencer #(.step_cycles_p(1)) u_b (
        .clk_i(clk), .reset_n_i(b_rst_n), .restart_i(b_restart), .heartbeat_i(b_hb),
        .link_reset_o(b_lrst), .link_enable_o(b_len), .chip_reset_o(b_crst),
        .node_en_o(b_nen), .done_o(b_done), .state_o(b_state), .timeout_count_o(b_tmo)
    );

    bsg_gateway_reset_sequencer #(.step_cycles_p(2), .watchdog_cycles_p(8)) u_c (
        .clk_i(clk), .reset_n_i(c_rst_n), .restart_i(c_restart), .heartbeat_i(c_hb),
        .link_reset_o(c_lrst), .link_enable_o(c_len), .chip_reset_o(c_crst),
        .node_en_o(c_nen), .done_o(c_done), .state_o(c_state), .timeout_count_o(c_tmo)
    );

    // Expected {link_reset, link_enable, chip_reset, node_en, done} per state
    function automatic logic [4:0] exp_outs(input int s);
        case (s)
            0:       return 5'b00100;
            1:       return 5'b10100;
            2:       return 5'b00100;
            3:       return 5'b01100;
            4:       return 5'b01000;
            default: return 5'b01011;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({a_lrst, a_len, a_crst, a_nen, a_done} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_outs_a: got %b want %b", {a_lrst, a_len, a_crst, a_nen, a_done}, 5'b00100);
        end
        n_cmp++;
        if (a_state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state_a: got %0d want 0", a_state);
        end
        n_cmp++;
        if (a_tmo !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_tmo_a: got %0d want 0", a_tmo);
        end
        n_cmp++;
        if ({b_state, b_lrst, b_len, b_crst, b_nen, b_done} !== 8'b000_00100) begin
            n_bad++;
            $display("FAIL reset_b: got %b want %b", {b_state, b_lrst, b_len, b_crst, b_nen, b_done}, 8'b000_00100);
        end
        n_cmp++;
        if ({c_state, c_lrst, c_len, c_crst, c_nen, c_done, c_tmo} !== {3'd0, 5'b00100, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_c: got %b want %b", {c_state, c_lrst, c_len, c_crst, c_nen, c_done, c_tmo}, {3'd0, 5'b00100, 8'd0});
        end
    endtask

    // N=4 from release: changes at edges 4, 8, 12, 16, 20
    task automatic test_sequence();
        int s;
        a_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            s = (k / 4 > 5) ? 5 : k / 4;
            n_cmp++;
            if ({a_state, a_lrst, a_len, a_crst, a_nen, a_done} !== {3'(s), exp_outs(s)}) begin
                n_bad++;
                $display("FAIL seq_edge%0d: got %b want %b", k,
                         {a_state, a_lrst, a_len, a_crst, a_nen, a_done}, {3'(s), exp_outs(s)});
            end
        end
    endtask

    // Restart driven after edge 14 is sampled at edge 15; done again at 35
    task automatic test_restart();
        a_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) tick();
        a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        n_cmp++;
        if ({a_state, a_crst, a_len, a_lrst} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL restart_edge15: got state=%0d crst=%b len=%b lrst=%b want 0 1 0 0",
                     a_state, a_crst, a_len, a_lrst);
        end
        for (int k = 16; k <= 19; k++) tick();
        n_cmp++;
        if ({a_state, a_lrst} !== {3'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL restart_edge19: got state=%0d lrst=%b want 1 1", a_state, a_lrst);
        end
        for (int k = 20; k <= 34; k++) tick();
        n_cmp++;
        if ({a_nen, a_done, a_state} !== {1'b0, 1'b0, 3'd4}) begin
            n_bad++;
            $display("FAIL restart_edge34: got nen=%b done=%b state=%0d want 0 0 4", a_nen, a_done, a_state);
        end
        tick();
        n_cmp++;
        if ({a_nen, a_done, a_state} !== {1'b1, 1'b1, 3'd5}) begin
            n_bad++;
            $display("FAIL restart_edge35: got nen=%b done=%b state=%0d want 1 1 5", a_nen, a_done, a_state);
        end
    endtask

    // Reset dropped between edges during S_CRUN, then full rerun
    task automatic test_async_reset();
        int s;
        a_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) tick();
        n_cmp++;
        if ({a_state, a_crst} !== {3'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL async_pre: got state=%0d crst=%b want 4 0", a_state, a_crst);
        end
        #2 a_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_state, a_lrst, a_len, a_crst, a_nen, a_done, a_tmo} !== {3'd0, 5'b00100, 8'd0}) begin
            n_bad++;
            $display("FAIL async_mid: got %b want %b",
                     {a_state, a_lrst, a_len, a_crst, a_nen, a_done, a_tmo}, {3'd0, 5'b00100, 8'd0});
        end
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 4 || k == 16 || k == 19 || k == 20) begin
                s = k / 4;
                n_cmp++;
                if ({a_state, a_lrst, a_len, a_crst, a_nen, a_done} !== {3'(s), exp_outs(s)}) begin
                    n_bad++;
                    $display("FAIL async_rerun_edge%0d: got %b want %b", k,
                             {a_state, a_lrst, a_len, a_crst, a_nen, a_done}, {3'(s), exp_outs(s)});
                end
            end
        end
    endtask

    // N=1: one state per edge, done at edge 5
    task automatic test_n1();
        int s;
        b_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 b_rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            s = (k > 5) ? 5 : k;
            n_cmp++;
            if ({b_state, b_lrst, b_len, b_crst, b_nen, b_done} !== {3'(s), exp_outs(s)}) begin
                n_bad++;
                $display("FAIL n1_edge%0d: got %b want %b", k,
                         {b_state, b_lrst, b_len, b_crst, b_nen, b_done}, {3'(s), exp_outs(s)});
            end
        end
    endtask

`ifdef BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN
    // N=2, watchdog 8, silent: done at 10, forced restart at 18, done at 28,
    // forced restart at 36
    task automatic test_watchdog();
        int s;
        int t;
        c_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 c_rst_n = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            tick();
            if (k < 18) begin
                s = (k / 2 > 5) ? 5 : k / 2;
                t = 0;
            end else if (k < 36) begin
                s = ((k - 18) / 2 > 5) ? 5 : (k - 18) / 2;
                t = 1;
            end else begin
                s = (k - 36) / 2;
                t = 2;
            end
            n_cmp++;
            if ({c_state, c_lrst, c_len, c_crst, c_nen, c_done, c_tmo} !== {3'(s), exp_outs(s), 8'(t)}) begin
                n_bad++;
                $display("FAIL wd_edge%0d: got state=%0d outs=%b tmo=%0d want state=%0d outs=%b tmo=%0d", k,
                         c_state, {c_lrst, c_len, c_crst, c_nen, c_done}, c_tmo, s, exp_outs(s), t);
            end
        end
    endtask

    // Heartbeat every 5 cycles keeps the node in S_DONE
    task automatic test_heartbeat();
        int leaves;
        leaves = 0;
        c_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 c_rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        for (int i = 0; i < 1000; i++) begin
            c_hb = (i % 5 == 0);
            tick();
            if (c_state !== 3'd5) leaves++;
        end
        c_hb = 1'b0;
        n_cmp++;
        if (leaves !== 0) begin
            n_bad++;
            $display("FAIL hb_stay_done: got %0d cycles outside S_DONE want 0", leaves);
        end
        n_cmp++;
        if (c_tmo !== 8'd0) begin
            n_bad++;
            $display("FAIL hb_tmo: got %0d want 0", c_tmo);
        end
    endtask
`else
    // Without the watchdog, silence never forces a restart
    task automatic test_no_watchdog();
        int leaves;
        leaves = 0;
        c_rst_n = 1'b0;
        tick();
        @(posedge clk);
        #1 c_rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        n_cmp++;
        if ({c_state, c_done} !== {3'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL nowd_done10: got state=%0d done=%b want 5 1", c_state, c_done);
        end
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (c_state !== 3'd5) leaves++;
        end
        n_cmp++;
        if (leaves !== 0) begin
            n_bad++;
            $display("FAIL nowd_stay_done: got %0d cycles outside S_DONE want 0", leaves);
        end
        n_cmp++;
        if (c_tmo !== 8'd0) begin
            n_bad++;
            $display("FAIL nowd_tmo: got %0d want 0", c_tmo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_restart();
        test_async_reset();
        test_n1();
`ifdef BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN
        test_watchdog();
        test_heartbeat();
`else
        test_no_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_gateway_reset_sequencer.md
BSG_GATEWAY_RESET_SEQUENCER -- requirements
Module: bsg_gateway_reset_sequencer

Interface
REQ-001 SHALL have parameter step_cycles_p, default 5000, giving the cycles spent in each sequencing step (legal range 1..65535).
REQ-002 SHALL have parameter watchdog_cycles_p, default 65535, giving the heartbeat timeout in cycles (legal range 1..2^20-1).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, which is the gateway core clock.
REQ-004 SHALL have port reset_n_i, input, 1 bit: asynchronous active-low reset, sourced from the board power-reset pin.
REQ-005 SHALL have port restart_i, input, 1 bit: synchronous request to re-run the sequence.
REQ-006 SHALL have port heartbeat_i, input, 1 bit: liveness pulse from the downstream node, such as a flit handshake.
REQ-007 SHALL have port link_reset_o, output, 1 bit: reset for the DDR link I/O logic.
REQ-008 SHALL have port link_enable_o, output, 1 bit: enable for the DDR link.
REQ-009 SHALL have port chip_reset_o, output, 1 bit: reset for the routers, channel tunnel and adapter.
REQ-010 SHALL have port node_en_o, output, 1 bit: enable for the traffic node.
REQ-011 SHALL have port done_o, output, 1 bit: high when the sequence is complete.
REQ-012 SHALL have port state_o, output, 3 bits: current state encoding.
REQ-013 SHALL have port timeout_count_o, output, 8 bits: number of watchdog restarts.

Function
REQ-014 SHALL implement states in the order S_PRE(0), S_LRST(1), S_LWAIT(2), S_LEN(3), S_CRUN(4), S_DONE(5).
REQ-015 SHALL stay exactly step_cycles_p cycles in each of S_PRE through S_CRUN, then advance to the next state; S_DONE is terminal except for restart or watchdog.
REQ-016 SHALL drive all outputs from registers as a Moore decode of state, with no combinational path from any input to any output.
REQ-017 SHALL decode link_reset_o=1 only in S_LRST.
REQ-018 SHALL decode link_enable_o=1 in S_LEN, S_CRUN and S_DONE.
REQ-019 SHALL decode chip_reset_o=0 only in S_CRUN and S_DONE.
REQ-020 SHALL decode node_en_o=1 and done_o=1 only in S_DONE.
REQ-021 SHALL, with release at edge 0 and N=step_cycles_p: raise link_reset_o at edge N, drop it at 2N, raise link_enable_o at 3N, drop chip_reset_o at 4N, and raise node_en_o and done_o at 5N.
REQ-022 SHALL, when restart_i=1 on any edge in any state, enter S_PRE with the step counter at 0 on the next edge, with outputs back at their reset values; restart_i has priority over step advance and over watchdog.
REQ-023 SHALL hold the S_PRE counter at 0 while restart_i stays high; the sequence begins on the first edge after it drops.
REQ-024 SHALL use a step counter wide enough for step_cycles_p with no wrap; the counter clears on every state change.

Reset
REQ-025 SHALL, while reset_n_i=0 (asynchronously): state=S_PRE, counters=0, link_reset_o=0, link_enable_o=0, chip_reset_o=1, node_en_o=0, done_o=0, state_o=0, timeout_count_o=0.
REQ-026 SHALL, on reset assertion mid-sequence, return all outputs to their reset values immediately, without waiting for a clock.

Configuration
REQ-027 SHALL, with macro BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN defined: in S_DONE, count cycles since the last heartbeat_i=1 (heartbeat clears the count); reaching watchdog_cycles_p forces S_PRE on the next edge and increments timeout_count_o, saturating at 255.
REQ-028 SHALL, without the macro: keep heartbeat_i present but ignore it, tie timeout_count_o to 0, and leave S_DONE only on restart_i; the port list is identical in both builds.

Structure
REQ-029 SHALL take the state enum typedef (3-bit) and the state encodings from shared package bsg_gateway_reset_seq_pkg.
REQ-030 SHALL place the clearable saturating up-counter, used for both the step timer and the watchdog, in one sub-module, bsg_gateway_reset_seq_timer.

Verification
REQ-031 SHALL cover: N=4, reset released -> edges 4/8/12/16/20 show link_reset_o rise, link_reset_o fall, link_enable_o rise, chip_reset_o fall, node_en_o=done_o=1.
REQ-032 SHALL cover: N=4, restart_i pulsed one cycle at edge 14 -> edge 15 shows chip_reset_o=1, link_enable_o=0, state_o=0, and node_en_o rises at edge 35.
REQ-033 SHALL cover: reset_n_i dropped mid-S_CRUN between edges -> outputs reach reset values before the next edge, and the full sequence re-runs after release.
REQ-034 SHALL cover: watchdog build, N=2, watchdog_cycles_p=8, no heartbeat after done -> restart 8 cycles after done_o rises, timeout_count_o=1, and the sequence repeats.
REQ-035 SHALL cover: watchdog build, heartbeat_i every 5 cycles -> no restart for 1000 cycles and timeout_count_o=0; the non-watchdog build with no heartbeat also gives no restart.
REQ-036 SHALL cover: N=1 -> each state lasts exactly one cycle and done_o is high at edge 5.
